mdu_sched: RTL and testbench
============================

# mdu_sched

Issue and sequencing controller for the multiply/divide unit (MDU) in the EX stage. It latches a MULT/MULTU/DIV/DIVU operation, holds the MDU inputs stable until the unit reports ready, and owns the architectural HI/LO registers. It generates the EX-stage stall and resolves hazards with MFHI/MFLO/MTHI/MTLO. On a pipeline flush it annuls or drains the in-flight operation.

## Interface
Parameters:
- none; widths are fixed at 32-bit operands and 64-bit results.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX holds a mul/div instruction; stays stable while stall=1.
- op_ctrl  in  5  MDU control code: `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL` or `DIVU_CONTROL`.
- op_a, op_b  in  32  rs and rt operands.
- hilo_rd  in  1  EX holds MFHI or MFLO.
- we_hi, we_lo  in  1  EX holds MTHI or MTLO.
- hilo_wdata  in  32  MTHI/MTLO data.
- flush  in  1  EX instruction is killed (exception or eret).
- mdu_ctrl  out  5  drives MDU.MDUControl.
- mdu_a, mdu_b  out  32  drive MDU.A and MDU.B.
- mdu_en  out  1  drives MDU.en.
- mdu_clear  out  1  drives MDU.clear.
- mdu_result  in  64  MDU.MDUResult; bits [63:32] go to HI, bits [31:0] go to LO.
- mdu_ready  in  1  MDU.MDUReady.
- hi, lo  out  32  architectural HI/LO values.
- stall  out  1  freeze IF..EX.
- busy  out  1  state is not IDLE.

## Operation
- Four states:
  - IDLE: the MDU is idle.
  - RUN: an operation is in flight.
  - DRAIN: a flushed divide is still running.
  - CLR: a one-cycle clear pulse.
- IDLE:
  - mdu_ctrl=0 (NOP), so the MDU start is low.
  - If op_valid & ~flush: latch op_ctrl, op_a and op_b, then go to RUN.
- RUN:
  - mdu_ctrl, mdu_a and mdu_b come from the latches; mdu_en=1.
  - If mdu_ready & ~flush: write HI/LO from mdu_result, go to IDLE.
  - If flush and the op is a multiply: go to CLR.
  - If flush and the op is a divide: go to DRAIN. The divider cannot be annulled.
  - If flush and mdu_ready arrive in the same cycle, flush wins: no write, go to IDLE.
- DRAIN:
  - Keep driving the latched divide.
  - On mdu_ready, discard the result and go to IDLE.
- CLR:
  - mdu_clear=1, mdu_ctrl=NOP, then go to IDLE.
- stall is asserted when any of the following holds:
  - op_valid & ~(state==RUN & mdu_ready), masked by flush;
  - (hilo_rd | we_hi | we_lo) & state!=IDLE;
  - op_valid & state is DRAIN or CLR.
- MTHI/MTLO write in IDLE only, and only when ~flush. Nothing is written while flush=1.
- A mul/div completion and an MTHI/MTLO write cannot both fire in one cycle. The stall rules already prevent it.
- op_ctrl values other than the four listed codes are ignored; the state stays IDLE.
- Divide by zero gets no special handling. Whatever the MDU returns is written.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, hi=lo=0, all latches 0, mdu_ctrl=0, mdu_en=0, mdu_clear=0, stall=0, busy=0.
- Issue at edge N: op_valid is seen in IDLE and accepted. RUN runs from cycle N+1.
- Completion: stall drops combinationally in the cycle mdu_ready=1. HI/LO update at the end of that cycle, and the EX instruction advances at the same edge.
- Total stall for an op = 1 + MDU latency in cycles.
- Back-to-back mul/div: the next op is accepted on the first IDLE cycle after completion, so there is at least 1 bubble.
- Reset asserted mid-operation: return to IDLE immediately. mdu_clear is not pulsed.

## Configuration
- `MDU_SCHED_HILO_BYPASS_EN`:
  - Defined: hi and lo outputs forward the value being written that cycle, from either mdu_result on completion or hilo_wdata on MTHI/MTLO. An MFHI/MFLO in the cycle right after a write sees the new value with no stall.
  - Undefined: hi and lo are plain register outputs.

## Structure
- defines2.vh gains:
  - the state encodings MDUS_IDLE, MDUS_RUN, MDUS_DRAIN and MDUS_CLR;
  - an is_div classification macro over the existing control codes.
- One sub-module, hilo_regs: the HI/LO flops with their write-enable and bypass muxing.
- mdu_sched instantiates hilo_regs and sits beside MDU in the datapath.

## Test plan
- MULT: op_a=0xFFFFFFFE (-2), op_b=3, MDU ready after 4 cycles.
  - Required: stall high for 5 cycles.
  - Then hi=0xFFFFFFFF and lo=0xFFFFFFFA on the following cycle.
- DIVU: op_a=100, op_b=7.
  - Required: hi=2, lo=14 after mdu_ready.
  - mdu_ctrl returns to 0 the next cycle.
- MFHI issued 1 cycle after a MULT is accepted.
  - Required: stall holds until completion; no HI/LO change before that.
- flush in the 2nd RUN cycle of a MULT.
  - Required: mdu_clear=1 for exactly 1 cycle.
  - HI/LO unchanged; state returns to IDLE in 2 cycles.
- flush during DIV, then a new MULTU presented.
  - Required: DRAIN until mdu_ready, with the result discarded and HI unchanged.
  - MULTU is stalled until IDLE, then completes correctly.
- MTLO of 0x12345678, then MFLO in the next cycle.
  - With the bypass macro: lo=0x12345678 in the write cycle.
  - Without it: lo=0x12345678 one cycle later.
  - In both cases rst=0 afterwards clears lo to 0 asynchronously.

Source files
------------

// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the MDU issue/sequencing controller: control codes,
// scheduler state encoding and operation classification helpers.
package mdu_sched_pkg;

  localparam logic [4:0] NOP_CONTROL   = 5'd0;
  localparam logic [4:0] MULT_CONTROL  = 5'd20;
  localparam logic [4:0] MULTU_CONTROL = 5'd21;
  localparam logic [4:0] DIV_CONTROL   = 5'd22;
  localparam logic [4:0] DIVU_CONTROL  = 5'd23;

  typedef enum logic [1:0] {
    MDUS_IDLE  = 2'd0,
    MDUS_RUN   = 2'd1,
    MDUS_DRAIN = 2'd2,
    MDUS_CLR   = 2'd3
  } mdus_state_e;

  function automatic logic is_div(input logic [4:0] ctrl);
    return (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);
  endfunction

  function automatic logic is_mdu_op(input logic [4:0] ctrl);
    return (ctrl == MULT_CONTROL) || (ctrl == MULTU_CONTROL) ||
           (ctrl == DIV_CONTROL)  || (ctrl == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Bundle between the EX stage / MDU and the MDU scheduler. The master side is
// the pipeline plus the MDU; the slave side is mdu_sched.
interface mdu_sched_if;
  logic        op_valid;
  logic [4:0]  op_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hilo_rd;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] hilo_wdata;
  logic        flush;
  logic [4:0]  mdu_ctrl;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_en;
  logic        mdu_clear;
  logic [63:0] mdu_result;
  logic        mdu_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        busy;

  modport master (
    output op_valid, op_ctrl, op_a, op_b, hilo_rd, we_hi, we_lo, hilo_wdata,
           flush, mdu_result, mdu_ready,
    input  mdu_ctrl, mdu_a, mdu_b, mdu_en, mdu_clear, hi, lo, stall, busy
  );

  modport slave (
    input  op_valid, op_ctrl, op_a, op_b, hilo_rd, we_hi, we_lo, hilo_wdata,
           flush, mdu_result, mdu_ready,
    output mdu_ctrl, mdu_a, mdu_b, mdu_en, mdu_clear, hi, lo, stall, busy
  );
endinterface

// File: rtl/mdu_sched_hilo_regs.sv
// Architectural HI/LO registers with write enables. When MDU_SCHED_HILO_BYPASS_EN
// is defined the outputs forward the value being written in the same cycle.
module hilo_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = wr_hi ? hi_wdata : hi_q;
    lo_d = wr_lo ? lo_wdata : lo_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef MDU_SCHED_HILO_BYPASS_EN
  // The next-state value already carries this cycle's write, so it doubles as the bypass.
  assign hi = hi_d;
  assign lo = lo_d;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

// File: rtl/mdu_sched.sv
// MDU issue/sequencing controller: holds MDU inputs for an operation, owns HI/LO,
// generates the EX stall, and annuls or drains on flush. Option: MDU_SCHED_HILO_BYPASS_EN.
module mdu_sched
  import mdu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mdu_sched_if.slave  bus
);

  mdus_state_e state_q, state_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic        mdu_wr;
  logic [4:0]  mdu_ctrl_o;
  logic        mdu_en_o;
  logic        mdu_clear_o;
  logic        op_go;
  logic        mt_ok;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  // Unknown control codes never start the unit, so they must not stall either.
  assign op_go = bus.op_valid & is_mdu_op(bus.op_ctrl);

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    mdu_wr      = 1'b0;
    mdu_ctrl_o  = NOP_CONTROL;
    mdu_en_o    = 1'b0;
    mdu_clear_o = 1'b0;
    case (state_q)
      MDUS_IDLE: begin
        if (op_go && !bus.flush) begin
          ctrl_d  = bus.op_ctrl;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          state_d = MDUS_RUN;
        end
      end
      MDUS_RUN: begin
        mdu_ctrl_o = ctrl_q;
        mdu_en_o   = 1'b1;
        // Flush beats a same-cycle ready; the divider cannot be annulled, only drained.
        if (bus.flush) begin
          state_d = is_div(ctrl_q) ? MDUS_DRAIN : MDUS_CLR;
        end else if (bus.mdu_ready) begin
          mdu_wr  = 1'b1;
          state_d = MDUS_IDLE;
        end
      end
      MDUS_DRAIN: begin
        mdu_ctrl_o = ctrl_q;
        mdu_en_o   = 1'b1;
        if (bus.mdu_ready) begin
          state_d = MDUS_IDLE;
        end
      end
      MDUS_CLR: begin
        mdu_clear_o = 1'b1;
        state_d     = MDUS_IDLE;
      end
      default: state_d = MDUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDUS_IDLE;
      ctrl_q  <= NOP_CONTROL;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // MTHI/MTLO only land in IDLE; the stall keeps them from colliding with a completion.
  assign mt_ok    = (state_q == MDUS_IDLE) & ~bus.flush;
  assign wr_hi    = mdu_wr | (mt_ok & bus.we_hi);
  assign wr_lo    = mdu_wr | (mt_ok & bus.we_lo);
  assign hi_wdata = mdu_wr ? bus.mdu_result[63:32] : bus.hilo_wdata;
  assign lo_wdata = mdu_wr ? bus.mdu_result[31:0]  : bus.hilo_wdata;

  hilo_regs u_hilo_regs (
    .clk      (clk),
    .rst      (rst),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi       (bus.hi),
    .lo       (bus.lo)
  );

  assign bus.stall = (op_go & ~((state_q == MDUS_RUN) & bus.mdu_ready) & ~bus.flush)
                   | ((bus.hilo_rd | bus.we_hi | bus.we_lo) & (state_q != MDUS_IDLE))
                   | (op_go & ((state_q == MDUS_DRAIN) | (state_q == MDUS_CLR)));

  assign bus.mdu_ctrl  = mdu_ctrl_o;
  assign bus.mdu_a     = a_q;
  assign bus.mdu_b     = b_q;
  assign bus.mdu_en    = mdu_en_o;
  assign bus.mdu_clear = mdu_clear_o;
  assign bus.busy      = (state_q != MDUS_IDLE);

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized bench for mdu_sched with a behavioural MDU stub of programmable latency
// and an architectural HI/LO reference model.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   mdu_cnt;
  int   mdu_lat = 4;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_sched_if bus ();

  mdu_sched dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result of an MDU op: HI = high product / remainder, LO = low product / quotient.
  function automatic logic [63:0] mdu_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] ea, eb, p;
    logic signed [31:0] q, r;
    sa = a;
    sb = b;
    ea = sa;
    eb = sb;
    case (c)
      MULT_CONTROL: begin
        p = ea * eb;
        return p;
      end
      MULTU_CONTROL: return {32'd0, a} * {32'd0, b};
      DIV_CONTROL: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      DIVU_CONTROL: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // MDU stub: ready comes after mdu_lat enabled cycles, computed from the held inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdu_cnt <= 0;
    else if (!bus.mdu_en || bus.mdu_ready) mdu_cnt <= 0;
    else mdu_cnt <= mdu_cnt + 1;
  end
  assign bus.mdu_ready  = bus.mdu_en && (mdu_cnt == mdu_lat);
  assign bus.mdu_result = mdu_model(bus.mdu_ctrl, bus.mdu_a, bus.mdu_b);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_expected(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = mdu_model(c, a, b);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  task automatic present(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op_ctrl  = c;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  // Plain issue-to-completion; stall must last 1 + latency cycles.
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input int lat);
    int n;
    mdu_lat = lat;
    @(posedge clk); #1;
    present(c, a, b);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      @(posedge clk); #1;
    end
    check_val("op_stall_cycles", 64'(n), 64'(lat + 1));
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    set_expected(c, a, b);
    @(negedge clk);
    check_val("op_hi", bus.hi, exp_hi);
    check_val("op_lo", bus.lo, exp_lo);
    check_val("op_ctrl_nop", bus.mdu_ctrl, NOP_CONTROL);
    check_val("op_idle", bus.busy, 1'b0);
  endtask

  // MTHI/MTLO followed by MFHI/MFLO in the next cycle.
  task automatic mt_write(input logic to_hi, input logic [31:0] d);
    logic [31:0] old;
    old = to_hi ? exp_hi : exp_lo;
    @(posedge clk); #1;
    bus.we_hi = to_hi;
    bus.we_lo = ~to_hi;
    bus.hilo_wdata = d;
    @(negedge clk);
    check_val("mt_stall", bus.stall, 1'b0);
`ifdef MDU_SCHED_HILO_BYPASS_EN
    check_val("mt_bypass", to_hi ? bus.hi : bus.lo, d);
`else
    check_val("mt_before", to_hi ? bus.hi : bus.lo, old);
`endif
    @(posedge clk); #1;
    bus.we_hi = 1'b0;
    bus.we_lo = 1'b0;
    bus.hilo_rd = 1'b1;
    if (to_hi) exp_hi = d; else exp_lo = d;
    @(negedge clk);
    check_val("mf_hi", bus.hi, exp_hi);
    check_val("mf_lo", bus.lo, exp_lo);
    @(posedge clk); #1;
    bus.hilo_rd = 1'b0;
  endtask

  // Flush in RUN cycle k (1..lat). Optionally present a MULTU during the drain.
  task automatic flush_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int k, input logic follow,
                          input logic [31:0] fa, input logic [31:0] fb);
    int n;
    logic stable;
    mdu_lat = lat;
    @(posedge clk); #1;
    present(c, a, b);
    repeat (k) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check_val("flush_stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    if (follow) present(MULTU_CONTROL, fa, fb);
    else bus.op_valid = 1'b0;
    if (!is_div(c)) begin
      @(negedge clk);
      check_val("clr_pulse", bus.mdu_clear, 1'b1);
      check_val("clr_ctrl", bus.mdu_ctrl, NOP_CONTROL);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("clr_once", bus.mdu_clear, 1'b0);
      check_val("clr_idle", bus.busy, 1'b0);
      bus.op_valid = 1'b0;
    end else if (!follow) begin
      n = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!bus.busy) break;
        n++;
        @(posedge clk); #1;
      end
      check_val("drain_cycles", 64'(n), 64'(lat - k + 1));
    end else begin
      n = 0;
      stable = 1'b1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!bus.stall) break;
        n++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) stable = 1'b0;
        @(posedge clk); #1;
      end
      check_val("drain_hilo_held", stable, 1'b1);
      check_val("drain_follow_stall", 64'(n), 64'((lat - k + 1) + 1 + lat));
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      set_expected(MULTU_CONTROL, fa, fb);
    end
    @(negedge clk);
    check_val("flush_hi", bus.hi, exp_hi);
    check_val("flush_lo", bus.lo, exp_lo);
  endtask

  // MFHI enters EX right after the op is accepted: stall through completion, HI/LO held until then.
  task automatic mf_during_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input int lat);
    int n;
    logic stable;
    mdu_lat = lat;
    @(posedge clk); #1;
    present(c, a, b);
    @(negedge clk);
    n = bus.stall ? 1 : 0;
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      bus.hilo_rd = 1'b1;
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      if (!bus.mdu_ready && (bus.hi !== exp_hi || bus.lo !== exp_lo)) stable = 1'b0;
    end
    check_val("mf_wait_cycles", 64'(n), 64'(lat + 2));
    check_val("mf_hilo_held", stable, 1'b1);
    set_expected(c, a, b);
    check_val("mf_hi_new", bus.hi, exp_hi);
    check_val("mf_lo_new", bus.lo, exp_lo);
    @(posedge clk); #1;
    bus.hilo_rd = 1'b0;
  endtask

  function automatic logic [4:0] rand_ctrl();
    case ($urandom_range(0, 3))
      0: return MULT_CONTROL;
      1: return MULTU_CONTROL;
      2: return DIV_CONTROL;
      default: return DIVU_CONTROL;
    endcase
  endfunction

  initial begin
    logic [4:0]  c;
    logic [31:0] a, b;
    int          lat;
    rst_n          = 1'b0;
    bus.op_valid   = 1'b0;
    bus.op_ctrl    = NOP_CONTROL;
    bus.op_a       = 32'd0;
    bus.op_b       = 32'd0;
    bus.hilo_rd    = 1'b0;
    bus.we_hi      = 1'b0;
    bus.we_lo      = 1'b0;
    bus.hilo_wdata = 32'd0;
    bus.flush      = 1'b0;
    #3;
    check_val("rst_hi", bus.hi, 32'd0);
    check_val("rst_lo", bus.lo, 32'd0);
    check_val("rst_ctrl", bus.mdu_ctrl, NOP_CONTROL);
    check_val("rst_en", bus.mdu_en, 1'b0);
    check_val("rst_clear", bus.mdu_clear, 1'b0);
    check_val("rst_stall", bus.stall, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(MULT_CONTROL, 32'hFFFF_FFFE, 32'd3, 4);
    run_op(DIVU_CONTROL, 32'd100, 32'd7, 5);
    mf_during_op(MULT_CONTROL, 32'd12345, 32'hFFFF_0001, 3);
    flush_op(MULT_CONTROL, 32'd77, 32'd88, 6, 2, 1'b0, 32'd0, 32'd0);
    flush_op(DIV_CONTROL, 32'hFFFF_FF00, 32'd9, 6, 2, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
    mt_write(1'b0, 32'h1234_5678);

    // Unknown control code is ignored.
    @(posedge clk); #1;
    present(5'd3, 32'd1, 32'd1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check_val("bad_ctrl_idle", bus.busy, 1'b0);

    for (int it = 0; it < 40; it++) begin
      c   = rand_ctrl();
      a   = $urandom;
      b   = $urandom;
      if (b == 32'd0) b = 32'd1;
      lat = $urandom_range(0, 6);
      case ($urandom_range(0, 9))
        6, 7: mt_write($urandom_range(0, 1) == 1, $urandom);
        8: begin
          if (lat == 0) lat = 1;
          flush_op(c, a, b, lat, $urandom_range(1, lat), is_div(c) && ($urandom_range(0, 1) == 1),
                   $urandom, $urandom);
        end
        9: mf_during_op(c, a, b, lat);
        default: run_op(c, a, b, lat);
      endcase
    end

    // Reset mid-operation returns to IDLE at once, clears HI/LO, no clear pulse.
    mdu_lat = 8;
    @(posedge clk); #1;
    present(DIV_CONTROL, 32'd1000, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", bus.busy, 1'b0);
    check_val("arst_en", bus.mdu_en, 1'b0);
    check_val("arst_clear", bus.mdu_clear, 1'b0);
    check_val("arst_hi", bus.hi, 32'd0);
    check_val("arst_lo", bus.lo, 32'd0);
    @(posedge clk); #1;
    check_val("arst_clear_held", bus.mdu_clear, 1'b0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
